counter_arbiter: RTL and testbench

//  Round-robin scheduler that shares one WIDTH-bit up-counter (register + incrementer)

---
 rtl/counter_arbiter_if.sv | 17 +
 rtl/counter_arbiter.sv | 120 ++++++++++++
 tb/tb_counter_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// Request/grant bundle between client FSMs and the shared-counter arbiter.
// The client side is the master; the arbiter is the slave.
interface counter_arbiter_if #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      cnt;
  logic                  busy;
  logic                  done;
  logic                  abort;

  modport master (output req, len, input gnt, cnt, busy, done, abort);
  modport slave  (input req, len, output gnt, cnt, busy, done, abort);
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin scheduler sharing one up-counter among NREQ requesters.
// state | meaning
// IDLE  | no owner; arbitrate among raised requests
// RUN   | counter stepping toward the winner's latched limit
// DONE  | limit reached; done pulses, grant released next cycle
module counter_arbiter #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst,
  counter_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic             abort_q, abort_d;

  logic [WIDTH-1:0] len_arr [NREQ];
  logic [PW-1:0]    win_c, idx_c, next_ptr;
  logic             found_c;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = bus.len[g*WIDTH +: WIDTH];
  end

  // First raised request scanning from ptr upward, wrapping.
  always_comb begin
    win_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx_c = PW'((int'(ptr_q) + i) % NREQ);
      if (!found_c && bus.req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  assign next_ptr = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found_c) begin
          gnt_d[win_c] = 1'b1;
          win_d        = win_c;
          cnt_d        = '0;
          limit_d      = len_arr[win_c];
          state_d      = (len_arr[win_c] != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Dropping the request wins over the final increment.
        if (!bus.req[win_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
          ptr_d   = next_ptr;
        end else if (cnt_q == limit_q - WIDTH'(1)) begin
          cnt_d   = limit_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = next_ptr;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt   = gnt_q;
    bus.cnt   = cnt_q;
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == DONE);
    bus.abort = abort_q;
  end
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed runs with a completion scoreboard
// plus per-cycle grant/pulse invariants.
module tb_counter_arbiter;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] cnt;
    logic       is_abort;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_m;

  counter_arbiter_if #(.WIDTH(3), .NREQ(4)) bus ();

  counter_arbiter #(.WIDTH(3), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] lens(input logic [2:0] l3, input logic [2:0] l2,
                                       input logic [2:0] l1, input logic [2:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Completion monitor and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("done_abort_excl", 32'(bus.done & bus.abort), 32'd0);
      chk("busy_vs_gnt", 32'(bus.busy), 32'(|bus.gnt));
      if (bus.done === 1'b1 || bus.abort === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 32'({bus.done, bus.abort}), 32'd0);
        end else begin
          e_m = sb_q.pop_front();
          chk("sb_kind", 32'(bus.abort), 32'(e_m.is_abort));
          chk("sb_gnt", 32'(bus.gnt), 32'(e_m.gnt));
          chk("sb_cnt", 32'(bus.cnt), 32'(e_m.cnt));
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_g;
    rst     = 1'b1;
    bus.req = 4'b1111;
    bus.len = lens(3'd1, 3'd1, 3'd1, 3'd1);

    // Reset held two cycles with all requests raised
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_cnt", 32'(bus.cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    bus.req = 4'b0000;
    rst     = 1'b0;
    mon_en  = 1'b1;
    tick();

    // Single run, len0=5
    bus.req = 4'b0001;
    bus.len = lens(3'd0, 3'd0, 3'd0, 3'd5);
    sb_q.push_back('{gnt: 4'b0001, cnt: 3'd5, is_abort: 1'b0});
    for (int k = 0; k <= 5; k++) begin
      tick();
      chk("single_gnt", 32'(bus.gnt), 32'h1);
      chk("single_cnt", 32'(bus.cnt), 32'(k));
      chk("single_done", 32'(bus.done), 32'(k == 5));
    end
    bus.req = 4'b0000;
    tick();
    chk("single_release_gnt", 32'(bus.gnt), 32'd0);
    chk("single_release_busy", 32'(bus.busy), 32'd0);

    // Fairness from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 4'b1111;
    bus.len = lens(3'd1, 3'd1, 3'd1, 3'd1);
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      sb_q.push_back('{gnt: exp_g, cnt: 3'd1, is_abort: 1'b0});
    end
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      tick();
      chk("fair_gnt0", 32'(bus.gnt), 32'(exp_g));
      chk("fair_cnt0", 32'(bus.cnt), 32'd0);
      tick();
      chk("fair_gnt1", 32'(bus.gnt), 32'(exp_g));
      chk("fair_done", 32'(bus.done), 32'd1);
      if (g == 4) bus.req = 4'b0000;
      tick();
      chk("fair_idle_gnt", 32'(bus.gnt), 32'd0);
    end
    tick();
    chk("fair_stay_idle", 32'(bus.busy), 32'd0);

    // len=0: single grant cycle straight into DONE
    bus.req = 4'b0010;
    bus.len = lens(3'd0, 3'd0, 3'd0, 3'd0);
    sb_q.push_back('{gnt: 4'b0010, cnt: 3'd0, is_abort: 1'b0});
    tick();
    chk("len0_gnt", 32'(bus.gnt), 32'h2);
    chk("len0_cnt", 32'(bus.cnt), 32'd0);
    chk("len0_done", 32'(bus.done), 32'd1);
    bus.req = 4'b0000;
    tick();
    chk("len0_release", 32'(bus.gnt), 32'd0);

    // len=7 to all-ones; len change after grant must be ignored
    bus.req = 4'b1000;
    bus.len = lens(3'd7, 3'd0, 3'd0, 3'd0);
    sb_q.push_back('{gnt: 4'b1000, cnt: 3'd7, is_abort: 1'b0});
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 0) bus.len = lens(3'd2, 3'd2, 3'd2, 3'd2);
      chk("len7_gnt", 32'(bus.gnt), 32'h8);
      chk("len7_cnt", 32'(bus.cnt), 32'(k));
      chk("len7_done", 32'(bus.done), 32'(k == 7));
    end
    bus.req = 4'b0000;
    tick();
    chk("len7_release", 32'(bus.gnt), 32'd0);

    // Abort mid-run, then pointer wrap 3 -> 0
    bus.req = 4'b0100;
    bus.len = lens(3'd0, 3'd6, 3'd0, 3'd0);
    sb_q.push_back('{gnt: 4'b0000, cnt: 3'd0, is_abort: 1'b1});
    for (int k = 0; k <= 3; k++) begin
      tick();
      chk("abort_run_gnt", 32'(bus.gnt), 32'h4);
      chk("abort_run_cnt", 32'(bus.cnt), 32'(k));
    end
    bus.req = 4'b0000;
    tick();
    chk("abort_pulse", 32'(bus.abort), 32'd1);
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_cnt", 32'(bus.cnt), 32'd0);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    bus.req = 4'b0101;
    bus.len = lens(3'd0, 3'd6, 3'd0, 3'd2);
    sb_q.push_back('{gnt: 4'b0001, cnt: 3'd2, is_abort: 1'b0});
    for (int k = 0; k <= 2; k++) begin
      tick();
      if (k == 0) chk("abort_pulse_clear", 32'(bus.abort), 32'd0);
      chk("wrap_gnt", 32'(bus.gnt), 32'h1);
      chk("wrap_cnt", 32'(bus.cnt), 32'(k));
    end
    bus.req = 4'b0000;
    tick();

    // Reset mid-run at cnt=4; pointer must return to 0
    bus.req = 4'b0100;
    bus.len = lens(3'd0, 3'd7, 3'd0, 3'd0);
    for (int k = 0; k <= 4; k++) begin
      tick();
      chk("midrst_cnt", 32'(bus.cnt), 32'(k));
    end
    rst = 1'b1;
    tick();
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_cnt0", 32'(bus.cnt), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_abort", 32'(bus.abort), 32'd0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    bus.len = lens(3'd1, 3'd1, 3'd1, 3'd1);
    sb_q.push_back('{gnt: 4'b0001, cnt: 3'd1, is_abort: 1'b0});
    tick();
    chk("midrst_ptr0_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0000;
    tick();
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
